// File: rtl/ram_dual_port.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, common clock.
// Optional build macro RAM_RDW_BYPASS_EN forwards write data to q on a same-address collision.
module ram_dual_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  output logic [DATA_W-1:0] q
);

  // Power-up contents are zero; reset_n never clears the array.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clock) begin
    if (reset_n && wren) begin
      mem[wraddress] <= data;
    end
  end

  always_comb begin
    rd_data_d = mem[rdaddress];
`ifdef RAM_RDW_BYPASS_EN
    if (wren && (wraddress == rdaddress)) begin
      rd_data_d = data;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else if (rden) begin
      q_q <= rd_data_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ram_dual_port.sv
// Self-checking bench for ram_dual_port: directed test-plan steps plus randomized traffic
// checked every cycle against an array-based reference model.
module tb_ram_dual_port;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 4096;

  logic              clock;
  logic              reset_n;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] wraddress;
  logic              wren;
  logic [ADDR_W-1:0] rdaddress;
  logic              rden;
  logic [DATA_W-1:0] q;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  ram_dual_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data     (data),
    .wraddress(wraddress),
    .wren     (wren),
    .rdaddress(rdaddress),
    .rden     (rden),
    .q        (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain array plus expected output word.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    exp_q = '0;
  end

  always @(posedge clock) begin
    logic [DATA_W-1:0] rd;
    if (reset_n) begin
      if (rden) begin
        rd = model_mem[rdaddress];
`ifdef RAM_RDW_BYPASS_EN
        if (wren && wraddress == rdaddress) rd = data;
`endif
        exp_q = rd;
      end
      if (wren) model_mem[wraddress] = data;
    end else begin
      exp_q = '0;
    end
  end

  always @(negedge reset_n) exp_q = '0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) check("model_compare", q, exp_q);
  end

  // Inputs change only at the falling edge; returns at the next falling edge.
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                     input logic re, input logic [ADDR_W-1:0] ra);
    wren      = we;
    wraddress = wa;
    data      = wd;
    rden      = re;
    rdaddress = ra;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1 check("async_reset_q", q, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    data      = '0;
    wraddress = '0;
    rdaddress = '0;
    #1 check("reset_q_initial", q, '0);
    @(negedge clock);
    started = 1'b1;

    // Writes during reset are ignored and q stays zero.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 12'd5, 32'hDEAD, 1'b1, 12'd5);
      check("reset_hold_q", q, '0);
    end
    reset_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b1, 12'd5);
    check("reset_write_ignored", q, '0);

    // Basic write/read at both ends of the address range.
    cyc(1'b1, 12'd0, 32'h11111111, 1'b0, '0);
    cyc(1'b1, 12'd4095, 32'hCAFEF00D, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 12'd0);
    check("basic_read_addr0", q, 32'h11111111);
    cyc(1'b0, '0, '0, 1'b1, 12'd4095);
    check("basic_read_addr4095", q, 32'hCAFEF00D);

    // Hold with rden low while the address wanders.
    cyc(1'b0, '0, '0, 1'b1, 12'd0);
    check("hold_setup", q, 32'h11111111);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0, 1'b0, ADDR_W'($urandom));
      check("hold_rden_low", q, 32'h11111111);
    end

    // Concurrent ports: write i, read i-1 each cycle.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, ADDR_W'(i), DATA_W'(i), 1'b1, ADDR_W'(i - 1));
      if (i >= 2) check("concurrent_read", q, DATA_W'(i - 1));
    end

    // Read-during-write collision.
    cyc(1'b1, 12'd7, 32'hA5, 1'b0, '0);
    cyc(1'b1, 12'd7, 32'h5A, 1'b1, 12'd7);
`ifdef RAM_RDW_BYPASS_EN
    check("collision_new_data", q, 32'h5A);
`else
    check("collision_old_data", q, 32'hA5);
`endif
    cyc(1'b0, '0, '0, 1'b1, 12'd7);
    check("collision_followup", q, 32'h5A);

    // Async reset between edges clears q but keeps the array.
    cyc(1'b0, '0, '0, 1'b1, 12'd4095);
    check("pre_reset_read", q, 32'hCAFEF00D);
    reset_pulse();
    cyc(1'b0, '0, '0, 1'b1, 12'd4095);
    check("array_kept_after_reset", q, 32'hCAFEF00D);

    // Randomized traffic over a narrow window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [ADDR_W-1:0] wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = wa;
      cyc(1'($urandom), wa, DATA_W'($urandom), 1'($urandom), ra);
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_dual_port.md
# ram_dual_port

Simple dual-port synchronous RAM, 4096 × 32, one write port and one read port on a common clock. Serves as the per-output-port packet buffer behind the switch buffer logic. Output ports write dequeued words here, and the host read path drains them through the read port.

## Interface
- `DATA_W`, default 32: word width in bits.
- `ADDR_W`, default 12: address width in bits.
- `DEPTH`, default 4096: number of words. Must equal 2**ADDR_W.

- `clock`  in  1: sole clock. All state updates on the rising edge.
- `reset_n`  in  1: reset. Asynchronous, active-low.
- `data`  in  DATA_W: write data.
- `wraddress`  in  ADDR_W: write address.
- `wren`  in  1: write enable, active-high.
- `rdaddress`  in  ADDR_W: read address.
- `rden`  in  1: read enable, active-high.
- `q`  out  DATA_W: registered read data.

## Operation
- Storage is an array of DEPTH words of DATA_W bits.
- All array words are zero at power-up/configuration. `reset_n` does not clear the array.
- Write:
  - On a rising edge with `wren`=1 and `reset_n`=1, `mem[wraddress]` <= `data`.
  - `wren`=0 leaves the array unchanged.
- Read:
  - On a rising edge with `rden`=1 and `reset_n`=1, `q` <= `mem[rdaddress]`.
  - With `rden`=0, `q` holds its previous value.
- Addresses are full-width unsigned. No out-of-range condition exists (DEPTH = 2**ADDR_W). No address wrap logic lives in the RAM; address counters belong to the caller.
- Read and write ports are fully independent. Both may be active on the same edge at different addresses.
- Read-during-write to the same address on the same edge (default build): `q` returns the old content. The new word is visible from the next read onward.
- Reset:
  - While `reset_n`=0, `q` = 0 and writes are ignored.
  - Asserting `reset_n` mid-operation clears `q` immediately, without waiting for a clock edge.
  - The first edge after deassertion behaves normally.

## Timing
- Read latency: 1 cycle. Address and `rden` are sampled at edge N; `q` is valid after edge N, i.e. during cycle N+1.
- Write latency: data is stored at edge N. A read of that address sampled at edge N+1 or later returns it.
- No handshake and no back-pressure. Every enabled access completes in one cycle, with sustained throughput of 1 write + 1 read per cycle.
- Reset value of every output: `q` = 0.
- `q` is driven directly from a flop, with no combinational path from any input to `q`.

## Configuration
- Macro: `RAM_RDW_BYPASS_EN`.
- Defined: on a same-edge read and write with `rden`=1, `wren`=1 and `rdaddress`==`wraddress`, `q` <= `data` (new-data forwarding). The array write is unchanged.
- Undefined: the same collision returns the old array content, as described in Operation.
- No other behaviour or latency changes in either build.

## Test plan
- Reset check: hold `reset_n`=0 for 3 edges with `wren`=1, `wraddress`=5, `data`=0xDEAD; then release and read address 5 -> `q` = 0 throughout reset, and address 5 still reads 0 (write ignored).
- Basic write/read: write 0x11111111 to addr 0 and 0xCAFEF00D to addr 4095, then read both -> `q` = 0x11111111 one cycle after the first read edge, then 0xCAFEF00D.
- Hold behaviour: read addr 0 (value 0x11111111), then drop `rden` for 4 cycles while changing `rdaddress` -> `q` stays 0x11111111.
- Concurrent ports: every cycle write `data`=i to addr i, and read addr i-1 with `rden`=1, for i = 1..16 -> `q` = i-1 each cycle after the first.
- Collision: addr 7 holds 0xA5; on one edge write 0x5A to addr 7 and read addr 7 -> `q` = 0xA5 (default) or 0x5A (`RAM_RDW_BYPASS_EN`). The next read of addr 7 returns 0x5A in both builds.
- Async reset mid-read: with `q` = 0xCAFEF00D, pulse `reset_n` low between clock edges -> `q` = 0 before the next edge, and the array contents are preserved.
